fphub_special_case_unit: RTL and testbench
==========================================

Name: fphub_special_case_unit

Overview:
- Multi-lane, pipelined special-operand classifier and bypass resolver for the FPHUB adder front end.
- Per lane, it classifies X and Y into the 7-code special-case set and decides whether the sum X+Y is fully determined without the main datapath. If so, it produces that bypass result.
- Sits between the operand source and the FPHUB adder core, with valid/ready flow control and a saturating special-case statistics counter.

Parameters:
- M, 23, mantissa width
- E, 8, exponent width
- LANES, 4, independent operand pairs per transaction
- CNT_W, 16, width of the saturating bypass counter
- Derived (localparam): W = E+M+1 (operand width); CW = 3 (case-code width).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  unit can accept an input transaction
- in_x  in  LANES*W  X operands; lane i occupies [i*W +: W]
- in_y  in  LANES*W  Y operands; same lane packing
- out_valid  out  1  output transaction valid
- out_ready  in  1  downstream accepts the output
- out_x_case  out  LANES*CW  X case code per lane
- out_y_case  out  LANES*CW  Y case code per lane
- out_bypass  out  LANES  1 = lane result fully resolved here
- out_result  out  LANES*W  bypass result; all-zero when the lane's bypass is 0
- out_invalid  out  LANES  +inf + -inf collision flag
- cnt_clear  in  1  synchronous clear of special_count
- special_count  out  CNT_W  saturating count of bypassed lanes

Behaviour:
- Case codes: 0 none, 1 +inf, 2 -inf, 3 +0, 4 -0, 5 +1, 6 -1. Code 7 is never produced.
- Classification, per operand, in priority order:
  - bits [W-2:0] all ones -> inf; sign selects code 1 or 2.
  - else bits [W-3:0] all zero and bit W-2 = 1 -> one; sign selects code 5 or 6.
  - else bits [W-3:0] all zero and bit W-2 = 0 -> zero; sign selects code 3 or 4.
  - else -> 0.
- Resolution, per lane, in priority order:
  - +inf and -inf: bypass=1, result=+inf (0,all ones), invalid=1.
  - exactly one inf, or both the same inf: bypass=1, result = that inf.
  - both zeros: bypass=1, result = +0 unless both are -0 (then -0).
  - X zero only: bypass=1, result=Y. Y zero only: bypass=1, result=X.
  - otherwise (including ±1 cases): bypass=0, result=0, invalid=0.
- Pipeline: 2 register stages.
  - S1 registers the raw operands and the classification codes.
  - S2 registers the resolution outputs (codes, bypass, result, invalid).
  - Latency is 2 cycles from input handshake to out_valid with no stall; throughput is 1 transaction per cycle.
- Handshake:
  - s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv.
  - A transfer occurs when valid && ready on that interface.
  - Data registers load only when their stage advances. Outputs are held stable while out_valid && !out_ready.
  - in_ready is combinational from out_ready and the stage valids. No combinational path from in_valid to out_valid.
- Counter:
  - On each output handshake, special_count += popcount(out_bypass), saturating at 2^CNT_W-1.
  - cnt_clear has priority over increment in the same cycle; the count becomes 0 and that cycle's increment is dropped.
- Reset (rst_n=0 at a clk edge):
  - s1_valid, s2_valid, out_valid = 0; special_count = 0; all data registers = 0.
  - Every output reads 0, except in_ready, which reads 1 from the first cycle after reset.
  - Reset mid-stream discards in-flight transactions and produces no partial outputs.

Decomposition:
- Package fphub_pkg holds:
  - typedef fphub_case_e, a 3-bit enum with CASE_NONE..CASE_ONE_N (values 0-6);
  - function classify(sign, body), parametrised via widths passed as arguments or via a parametrised class;
  - localparam CW=3.
- One sub-module, fphub_lane_resolver: combinational; inputs are two W-bit operands and two codes; outputs are bypass, result and invalid. It is instantiated LANES times via generate.
- The pipeline, handshake and counter stay in the top module.

Test Plan (E=8, M=23, LANES=4):
- Classification sweep:
  - lanes X = {0x7FFFFFFF, 0xFFFFFFFF, 0x40000000, 0xC0000000}, Y = {0x00000000, 0x80000000, 0x3F800000, 0x12345678}
  - -> x_case = {1,2,5,6}, y_case = {3,4,0,0}; out_valid exactly 2 cycles after the input handshake.
- Resolution:
  - lane0 X=0x7FFFFFFF, Y=0xFFFFFFFF -> bypass=1, result=0x7FFFFFFF, invalid=1.
  - lane1 X=0x80000000, Y=0x80000000 -> result=0x80000000.
  - lane2 X=0x00000000, Y=0x3F800000 -> result=0x3F800000.
  - lane3 X=0x40000000, Y=0x40000000 -> bypass=0, result=0.
- Backpressure:
  - out_ready=0 for 5 cycles with in_valid=1 streaming -> in_ready drops after 2 accepts; out data stays stable.
  - On release, all transactions emerge in order with none lost or duplicated.
- Counter:
  - 3 transactions with 4, 2, 0 bypassed lanes -> special_count=6.
  - With CNT_W=3, after 8 bypassed lanes -> saturates at 7.
  - cnt_clear asserted on a handshake cycle -> special_count=0.
- Reset mid-operation:
  - rst_n=0 for 1 cycle with both stages valid -> out_valid=0, in_ready=1, special_count=0 on the next cycle; no stale data appears afterwards.
- Random regression: 10k random operands with 25% special injection and random out_ready -> scoreboard matches the reference classifier per lane.

Source files
------------

// File: rtl/fphub_pkg.sv
// Shared types and the operand classifier for the FPHUB special-case front end.
// The classifier walks a fixed-width body vector so one function serves any operand width.
package fphub_pkg;

  localparam int CW         = 3;
  localparam int MAX_BODY_W = 128;

  typedef enum logic [CW-1:0] {
    CASE_NONE   = 3'd0,
    CASE_INF_P  = 3'd1,
    CASE_INF_N  = 3'd2,
    CASE_ZERO_P = 3'd3,
    CASE_ZERO_N = 3'd4,
    CASE_ONE_P  = 3'd5,
    CASE_ONE_N  = 3'd6
  } fphub_case_e;

  // body holds the operand without its sign, zero-extended; bw is its real width.
  function automatic fphub_case_e classify(input logic                  sign,
                                           input logic [MAX_BODY_W-1:0] body,
                                           input int                    bw);
    logic all_ones;
    logic low_zero;
    logic top;
    all_ones = 1'b1;
    low_zero = 1'b1;
    top      = 1'b0;
    for (int i = 0; i < MAX_BODY_W; i++) begin
      if (i < bw)      all_ones = all_ones & body[i];
      if (i < bw - 1)  low_zero = low_zero & ~body[i];
      if (i == bw - 1) top      = body[i];
    end
    if (all_ones)      return sign ? CASE_INF_N : CASE_INF_P;
    else if (!low_zero) return CASE_NONE;
    else if (top)       return sign ? CASE_ONE_N : CASE_ONE_P;
    else                return sign ? CASE_ZERO_N : CASE_ZERO_P;
  endfunction

  function automatic logic is_inf(input fphub_case_e c);
    return (c == CASE_INF_P) || (c == CASE_INF_N);
  endfunction

  function automatic logic is_zero(input fphub_case_e c);
    return (c == CASE_ZERO_P) || (c == CASE_ZERO_N);
  endfunction

endpackage

// File: rtl/fphub_lane_resolver.sv
// Per-lane bypass resolver: decides from the two case codes whether X+Y is known
// without the adder core and, if so, produces that sum.
module fphub_lane_resolver
  import fphub_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  fphub_case_e  i_x_case,
  input  fphub_case_e  i_y_case,
  output logic         o_bypass,
  output logic [W-1:0] o_result,
  output logic         o_invalid
);

  logic w_x_inf;
  logic w_y_inf;
  logic w_x_zero;
  logic w_y_zero;

  assign w_x_inf  = is_inf(i_x_case);
  assign w_y_inf  = is_inf(i_y_case);
  assign w_x_zero = is_zero(i_x_case);
  assign w_y_zero = is_zero(i_y_case);

  // Inf codes imply the raw operand is exactly the inf pattern, so forwarding it is safe.
  always_comb begin
    o_bypass  = 1'b0;
    o_result  = '0;
    o_invalid = 1'b0;
    if (w_x_inf && w_y_inf && (i_x_case != i_y_case)) begin
      o_bypass  = 1'b1;
      o_result  = {1'b0, {(W-1){1'b1}}};
      o_invalid = 1'b1;
    end else if (w_x_inf) begin
      o_bypass = 1'b1;
      o_result = i_x;
    end else if (w_y_inf) begin
      o_bypass = 1'b1;
      o_result = i_y;
    end else if (w_x_zero && w_y_zero) begin
      o_bypass = 1'b1;
      o_result = ((i_x_case == CASE_ZERO_N) && (i_y_case == CASE_ZERO_N)) ?
                 {1'b1, {(W-1){1'b0}}} : '0;
    end else if (w_x_zero) begin
      o_bypass = 1'b1;
      o_result = i_y;
    end else if (w_y_zero) begin
      o_bypass = 1'b1;
      o_result = i_x;
    end
  end

endmodule

// File: rtl/fphub_special_case_unit.sv
// Multi-lane special-operand classifier and bypass resolver in front of the FPHUB adder:
// two register stages with valid/ready flow control and a saturating bypass counter.
module fphub_special_case_unit
  import fphub_pkg::*;
#(
  parameter  int M     = 23,
  parameter  int E     = 8,
  parameter  int LANES = 4,
  parameter  int CNT_W = 16,
  localparam int W     = E + M + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*W-1:0]    in_x,
  input  logic [LANES*W-1:0]    in_y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*CW-1:0]   out_x_case,
  output logic [LANES*CW-1:0]   out_y_case,
  output logic [LANES-1:0]      out_bypass,
  output logic [LANES*W-1:0]    out_result,
  output logic [LANES-1:0]      out_invalid,
  input  logic                  cnt_clear,
  output logic [CNT_W-1:0]      special_count
);

  localparam int PCW   = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + PCW + 1;
  localparam logic [SUM_W-1:0] CNT_SAT = SUM_W'({CNT_W{1'b1}});

  logic             r_s1_valid;
  logic             r_s2_valid;
  logic             w_s1_adv;
  logic             w_s2_adv;
  logic [CNT_W-1:0] r_count;
  logic [PCW-1:0]   w_pop;
  logic [SUM_W-1:0] w_sum;

  // A stage may load when it is empty or the stage after it is draining.
  assign w_s2_adv      = !r_s2_valid || out_ready;
  assign w_s1_adv      = !r_s1_valid || w_s2_adv;
  assign in_ready      = w_s1_adv;
  assign out_valid     = r_s2_valid;
  assign special_count = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_valid <= in_valid;
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [W-1:0] w_x;
      logic [W-1:0] w_y;
      fphub_case_e  w_x_case;
      fphub_case_e  w_y_case;
      logic [W-1:0] r_s1_x;
      logic [W-1:0] r_s1_y;
      fphub_case_e  r_s1_x_case;
      fphub_case_e  r_s1_y_case;
      logic         w_bypass;
      logic [W-1:0] w_result;
      logic         w_invalid;
      fphub_case_e  r_s2_x_case;
      fphub_case_e  r_s2_y_case;
      logic         r_s2_bypass;
      logic [W-1:0] r_s2_result;
      logic         r_s2_invalid;

      assign w_x      = in_x[gi*W +: W];
      assign w_y      = in_y[gi*W +: W];
      assign w_x_case = classify(w_x[W-1], MAX_BODY_W'(w_x[W-2:0]), W - 1);
      assign w_y_case = classify(w_y[W-1], MAX_BODY_W'(w_y[W-2:0]), W - 1);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_s1_x      <= '0;
          r_s1_y      <= '0;
          r_s1_x_case <= CASE_NONE;
          r_s1_y_case <= CASE_NONE;
        end else if (w_s1_adv) begin
          r_s1_x      <= w_x;
          r_s1_y      <= w_y;
          r_s1_x_case <= w_x_case;
          r_s1_y_case <= w_y_case;
        end
      end

      fphub_lane_resolver #(
        .W (W)
      ) u_resolver (
        .i_x      (r_s1_x),
        .i_y      (r_s1_y),
        .i_x_case (r_s1_x_case),
        .i_y_case (r_s1_y_case),
        .o_bypass (w_bypass),
        .o_result (w_result),
        .o_invalid(w_invalid)
      );

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_s2_x_case  <= CASE_NONE;
          r_s2_y_case  <= CASE_NONE;
          r_s2_bypass  <= 1'b0;
          r_s2_result  <= '0;
          r_s2_invalid <= 1'b0;
        end else if (w_s2_adv) begin
          r_s2_x_case  <= r_s1_x_case;
          r_s2_y_case  <= r_s1_y_case;
          r_s2_bypass  <= w_bypass;
          r_s2_result  <= w_result;
          r_s2_invalid <= w_invalid;
        end
      end

      assign out_x_case[gi*CW +: CW] = r_s2_x_case;
      assign out_y_case[gi*CW +: CW] = r_s2_y_case;
      assign out_bypass[gi]          = r_s2_bypass;
      assign out_result[gi*W +: W]   = r_s2_result;
      assign out_invalid[gi]         = r_s2_invalid;
    end
  endgenerate

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pop = w_pop + PCW'(out_bypass[i]);
    end
  end

  assign w_sum = SUM_W'(r_count) + SUM_W'(w_pop);

  // A clear in the same cycle as a handshake wins and drops that cycle's increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (cnt_clear) begin
      r_count <= '0;
    end else if (r_s2_valid && out_ready) begin
      r_count <= (w_sum > CNT_SAT) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_fphub_special_case_unit.sv
// Directed-vector and scoreboard bench for fphub_special_case_unit (E=8, M=23, 4 lanes);
// a second instance with a 3-bit counter covers saturation.
module tb_fphub_special_case_unit;

  typedef struct packed {
    logic [11:0]  xc;
    logic [11:0]  yc;
    logic [3:0]   byp;
    logic [127:0] res;
    logic [3:0]   inv;
  } out_t;

  typedef struct {
    logic [127:0] x;
    logic [127:0] y;
    out_t         e;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         cnt_clear = 1'b0;
  logic [127:0] in_x = '0;
  logic [127:0] in_y = '0;

  logic         in_ready, out_valid;
  logic [11:0]  out_x_case, out_y_case;
  logic [3:0]   out_bypass, out_invalid;
  logic [127:0] out_result;
  logic [15:0]  special_count;

  logic         s_in_ready, s_out_valid;
  logic [11:0]  s_out_x_case, s_out_y_case;
  logic [3:0]   s_out_bypass, s_out_invalid;
  logic [127:0] s_out_result;
  logic [2:0]   s_special_count;

  fphub_special_case_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
    .out_x_case(out_x_case), .out_y_case(out_y_case), .out_bypass(out_bypass),
    .out_result(out_result), .out_invalid(out_invalid), .cnt_clear(cnt_clear),
    .special_count(special_count)
  );

  fphub_special_case_unit #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_x(in_x), .in_y(in_y), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_x_case(s_out_x_case), .out_y_case(s_out_y_case), .out_bypass(s_out_bypass),
    .out_result(s_out_result), .out_invalid(s_out_invalid), .cnt_clear(cnt_clear),
    .special_count(s_special_count)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl [6];
  out_t obs_q [$];
  out_t exp_q [$];
  out_t mon;
  int   idx;
  bit   done;

  // Outputs are captured half a cycle ahead of the edge that completes the handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon.xc  = out_x_case;
      mon.yc  = out_y_case;
      mon.byp = out_bypass;
      mon.res = out_result;
      mon.inv = out_invalid;
      obs_q.push_back(mon);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic check_out(input string tag, input out_t got, input out_t exp);
    check({tag, "_xcase"},   got.xc,  exp.xc);
    check({tag, "_ycase"},   got.yc,  exp.yc);
    check({tag, "_bypass"},  got.byp, exp.byp);
    check({tag, "_result"},  got.res, exp.res);
    check({tag, "_invalid"}, got.inv, exp.inv);
  endtask

  task automatic send(input logic [127:0] x, input logic [127:0] y);
    bit acc;
    acc      = 1'b0;
    in_x     = x;
    in_y     = y;
    in_valid = 1'b1;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else tick();
    end
    if (acc) tick();
    else fail_timeout("send_accept");
    in_valid = 1'b0;
  endtask

  task automatic get_out(output out_t o, output bit got);
    o   = '0;
    got = 1'b0;
    for (int c = 0; c < 50 && obs_q.size() == 0; c++) tick();
    if (obs_q.size() > 0) begin
      o   = obs_q.pop_front();
      got = 1'b1;
    end else begin
      fail_timeout("get_out");
    end
  endtask

  function automatic logic [2:0] ref_case(input logic [31:0] v);
    if (v[30:0] == 31'h7FFFFFFF) return v[31] ? 3'd2 : 3'd1;
    if (v[30:0] == 31'h40000000) return v[31] ? 3'd6 : 3'd5;
    if (v[30:0] == 31'h00000000) return v[31] ? 3'd4 : 3'd3;
    return 3'd0;
  endfunction

  function automatic out_t ref_model(input logic [127:0] x, input logic [127:0] y);
    out_t r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      logic [2:0]  ca, cb;
      a = x[i*32 +: 32];
      b = y[i*32 +: 32];
      ca = ref_case(a);
      cb = ref_case(b);
      r.xc[i*3 +: 3] = ca;
      r.yc[i*3 +: 3] = cb;
      if ((ca == 3'd1 && cb == 3'd2) || (ca == 3'd2 && cb == 3'd1)) begin
        r.byp[i] = 1'b1; r.res[i*32 +: 32] = 32'h7FFFFFFF; r.inv[i] = 1'b1;
      end else if (ca == 3'd1 || ca == 3'd2) begin
        r.byp[i] = 1'b1; r.res[i*32 +: 32] = a;
      end else if (cb == 3'd1 || cb == 3'd2) begin
        r.byp[i] = 1'b1; r.res[i*32 +: 32] = b;
      end else if ((ca == 3'd3 || ca == 3'd4) && (cb == 3'd3 || cb == 3'd4)) begin
        r.byp[i] = 1'b1;
        r.res[i*32 +: 32] = (ca == 3'd4 && cb == 3'd4) ? 32'h80000000 : 32'h0;
      end else if (ca == 3'd3 || ca == 3'd4) begin
        r.byp[i] = 1'b1; r.res[i*32 +: 32] = b;
      end else if (cb == 3'd3 || cb == 3'd4) begin
        r.byp[i] = 1'b1; r.res[i*32 +: 32] = a;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 5))
        0:       return 32'h7FFFFFFF;
        1:       return 32'hFFFFFFFF;
        2:       return 32'h00000000;
        3:       return 32'h80000000;
        4:       return 32'h40000000;
        default: return 32'hC0000000;
      endcase
    end
    return $urandom();
  endfunction

  task automatic bp_step();
    bit adv;
    @(negedge clk);
    adv = in_ready;
    if (!out_ready && out_valid) check("bp_stable_result", out_result, tbl[0].e.res);
    tick();
    if (adv) begin
      idx++;
      if (idx < 5) begin
        in_x = tbl[idx].x;
        in_y = tbl[idx].y;
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t o;
    bit   got;
    int   cum;
    int   accepts;

    tbl[0].x = {32'hC0000000, 32'h40000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
    tbl[0].y = {32'h12345678, 32'h3F800000, 32'h80000000, 32'h00000000};
    tbl[0].e = '{xc: {3'd6, 3'd5, 3'd2, 3'd1}, yc: {3'd0, 3'd0, 3'd4, 3'd3}, byp: 4'b0011,
                 res: {32'h0, 32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF}, inv: 4'b0000};
    tbl[1].x = {32'h40000000, 32'h00000000, 32'h80000000, 32'h7FFFFFFF};
    tbl[1].y = {32'h40000000, 32'h3F800000, 32'h80000000, 32'hFFFFFFFF};
    tbl[1].e = '{xc: {3'd5, 3'd3, 3'd4, 3'd1}, yc: {3'd5, 3'd0, 3'd4, 3'd2}, byp: 4'b0111,
                 res: {32'h0, 32'h3F800000, 32'h80000000, 32'h7FFFFFFF}, inv: 4'b0001};
    tbl[2].x = {32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'h00000000};
    tbl[2].y = {32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    tbl[2].e = '{xc: {3'd2, 3'd0, 3'd2, 3'd3}, yc: {3'd1, 3'd4, 3'd2, 3'd4}, byp: 4'b1111,
                 res: {32'h7FFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'h00000000}, inv: 4'b1000};
    tbl[3].x = {32'h00000001, 32'hC0000000, 32'h7FFFFFFE, 32'h7F800000};
    tbl[3].y = {32'h80000000, 32'h00000000, 32'hBF800000, 32'h3F800000};
    tbl[3].e = '{xc: {3'd0, 3'd6, 3'd0, 3'd0}, yc: {3'd4, 3'd3, 3'd0, 3'd0}, byp: 4'b1100,
                 res: {32'h00000001, 32'hC0000000, 32'h0, 32'h0}, inv: 4'b0000};
    tbl[4].x = {32'h80000000, 32'hDEADBEEF, 32'h40000000, 32'h80000000};
    tbl[4].y = {32'h80000001, 32'h12345678, 32'h00000000, 32'h7FFFFFFF};
    tbl[4].e = '{xc: {3'd4, 3'd0, 3'd5, 3'd4}, yc: {3'd0, 3'd0, 3'd3, 3'd1}, byp: 4'b1011,
                 res: {32'h80000001, 32'h0, 32'h40000000, 32'h7FFFFFFF}, inv: 4'b0000};
    tbl[5].x = {4{32'h3F800000}};
    tbl[5].y = {4{32'h12345678}};
    tbl[5].e = '0;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_count", special_count, 16'd0);
    check("rst_result", out_result, 128'd0);
    check("rst_bypass", out_bypass, 4'd0);
    check("rst_xcase", out_x_case, 12'd0);

    // Latency on the classification sweep vector
    send(tbl[0].x, tbl[0].y);
    @(negedge clk);
    check("lat_cycle1_out_valid", out_valid, 1'b0);
    @(negedge clk);
    check("lat_cycle2_out_valid", out_valid, 1'b1);
    get_out(o, got);
    if (got) check_out("vec0", o, tbl[0].e);
    cum = 2;
    check("cnt_vec0", special_count, 16'(cum));
    check("cnt_sat_vec0", s_special_count, 3'(cum));

    // Table-driven vectors with running counter totals
    for (int i = 1; i < 6; i++) begin
      send(tbl[i].x, tbl[i].y);
      get_out(o, got);
      if (got) check_out($sformatf("vec%0d", i), o, tbl[i].e);
      cum += $countones(tbl[i].e.byp);
      check($sformatf("cnt_vec%0d", i), special_count, 16'(cum));
      check($sformatf("cnt_sat_vec%0d", i), s_special_count, (cum > 7) ? 3'd7 : 3'(cum));
    end

    // Counter: 4 + 2 + 0 bypassed lanes after a clear
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    check("cnt_after_clear", special_count, 16'd0);
    send(tbl[2].x, tbl[2].y);
    get_out(o, got);
    send(tbl[3].x, tbl[3].y);
    get_out(o, got);
    send(tbl[5].x, tbl[5].y);
    get_out(o, got);
    check("cnt_420", special_count, 16'd6);
    check("cnt_sat_420", s_special_count, 3'd6);

    // Clear on the same edge as an output handshake
    send(tbl[2].x, tbl[2].y);
    tick();
    cnt_clear = 1'b1;
    @(negedge clk);
    check("clr_hs_out_valid", out_valid, 1'b1);
    tick();
    cnt_clear = 1'b0;
    check("clr_hs_count", special_count, 16'd0);
    check("clr_hs_sat_count", s_special_count, 3'd0);
    tick();
    check("clr_hs_count_hold", special_count, 16'd0);
    obs_q.delete();

    // Backpressure: stall the output while streaming
    out_ready = 1'b0;
    idx       = 0;
    in_x      = tbl[0].x;
    in_y      = tbl[0].y;
    in_valid  = 1'b1;
    for (int c = 0; c < 5; c++) bp_step();
    accepts = idx;
    check("bp_accepts", 32'(accepts), 32'd2);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    check("bp_hold_result", out_result, tbl[0].e.res);
    check("bp_hold_xcase", out_x_case, tbl[0].e.xc);
    out_ready = 1'b1;
    for (int c = 0; c < 50 && idx < 5; c++) bp_step();
    in_valid = 1'b0;
    if (idx < 5) fail_timeout("bp_stream");
    for (int j = 0; j < 5; j++) begin
      get_out(o, got);
      if (got) check_out($sformatf("bp_order%0d", j), o, tbl[j].e);
    end
    tick();
    tick();
    check("bp_no_dup", 32'(obs_q.size()), 32'd0);

    // Reset with both stages holding data
    out_ready = 1'b0;
    send(tbl[1].x, tbl[1].y);
    send(tbl[2].x, tbl[2].y);
    check("pre_rst_out_valid", out_valid, 1'b1);
    check("pre_rst_in_ready", in_ready, 1'b0);
    check("pre_rst_count", special_count, 16'd14);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_count", special_count, 16'd0);
    check("mid_rst_result", out_result, 128'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    check("mid_rst_no_stale", 32'(obs_q.size()), 32'd0);
    check("mid_rst_idle_valid", out_valid, 1'b0);

    // Random regression against the reference model
    done = 1'b0;
    fork
      begin
        for (int t = 0; t < 2500; t++) begin
          logic [127:0] rx, ry;
          for (int l = 0; l < 4; l++) begin
            rx[l*32 +: 32] = rand_op();
            ry[l*32 +: 32] = rand_op();
          end
          if ($urandom_range(0, 7) == 0) tick();
          exp_q.push_back(ref_model(rx, ry));
          send(rx, ry);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    for (int c = 0; c < 100 && obs_q.size() < exp_q.size(); c++) tick();
    tick();
    check("rnd_txn_count", 32'(obs_q.size()), 32'(exp_q.size()));
    cum = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      out_t e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      cum += $countones(e.byp);
      check_out("rnd", o, e);
    end
    check("rnd_count", special_count, 16'(cum));
    check("rnd_sat_count", s_special_count, (cum > 7) ? 3'd7 : 3'(cum));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
